// File: rtl/io_bus_pkg.sv
// Shared definitions for the I/O bus arbiter: FSM encoding, idle address and the
// memory-mapped device namespace used by decoders and benches.
package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'h0000_0000;

    localparam logic [31:0] HEX_ADDR   = 32'hF000_0000;
    localparam logic [31:0] LEDR_ADDR  = 32'hF000_0004;
    localparam logic [31:0] KEY_ADDR   = 32'hF000_0010;
    localparam logic [31:0] SW_ADDR    = 32'hF000_0014;
    localparam logic [31:0] TIMER_ADDR = 32'hF000_0020;

    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Master-side handshake of the I/O bus arbiter: two request ports plus the
// shared completion/read-data return path.
interface io_bus_arbiter_if #(
    parameter int DBITS = 32
);
    logic             req0, req1;
    logic             lock0, lock1;
    logic             we0, we1;
    logic [DBITS-1:0] addr0, addr1;
    logic [DBITS-1:0] wdata0, wdata1;
    logic             ack0, ack1;
    logic [DBITS-1:0] rdata;
    logic [1:0]       gnt;

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata, gnt
    );

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata, gnt
    );
endinterface

// File: rtl/io_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a conflict the master that did
// not win last time is chosen.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    output logic winner,
    output logic valid
);
    always_comb begin
        valid  = req0 | req1;
        winner = (req0 && req1) ? ~rr_last : req1;
    end
endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the memory-mapped I/O bus: one registered transfer per
// grant (XFER then DONE/ack), round-robin fairness, capped locked bursts.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int               DBITS     = 32,
    parameter logic [DBITS-1:0] IDLE_ADDR = DBITS'(IDLE_ADDR_DEFAULT),
    parameter int               MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    io_bus_arbiter_if.slave  bus,
    output logic [DBITS-1:0] address,
    output logic             wrtEn,
    inout  wire  [DBITS-1:0] dbus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    state_t           state, state_nxt;
    logic             owner;
    logic             rr_last;
    logic [CW-1:0]    burst_cnt;
    logic [DBITS-1:0] lat_wdata;

    logic             pick_winner, pick_valid;
    logic             do_grant, grant_id, grant_cont;
    logic             owner_req, owner_lock;

    rr_pick2 u_pick (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .rr_last (rr_last),
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        grant_id   = pick_winner;
        grant_cont = 1'b0;
        owner_req  = owner ? bus.req1  : bus.req0;
        owner_lock = owner ? bus.lock1 : bus.lock0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ST_XFER;
                    do_grant  = 1'b1;
                end
            end
            ST_XFER: state_nxt = ST_DONE;
            ST_DONE: begin
                // A locked owner keeps the bus only while under the burst cap;
                // otherwise it competes like anyone else, with rr_last == owner.
                if (owner_lock && owner_req && (int'(burst_cnt) < MAX_BURST)) begin
                    state_nxt  = ST_XFER;
                    do_grant   = 1'b1;
                    grant_id   = owner;
                    grant_cont = 1'b1;
                end else if (pick_valid) begin
                    state_nxt = ST_XFER;
                    do_grant  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= 1'b0;
            rr_last   <= 1'b1;
            burst_cnt <= '0;
            bus.gnt   <= 2'b00;
            bus.ack0  <= 1'b0;
            bus.ack1  <= 1'b0;
            bus.rdata <= '0;
            address   <= IDLE_ADDR;
            wrtEn     <= 1'b0;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            if (do_grant) begin
                owner     <= grant_id;
                rr_last   <= grant_id;
                bus.gnt   <= onehot2(grant_id);
                burst_cnt <= grant_cont ? burst_cnt + CW'(1) : CW'(1);
                address   <= grant_id ? bus.addr1 : bus.addr0;
                wrtEn     <= grant_id ? bus.we1   : bus.we0;
            end else if (state == ST_XFER) begin
                address  <= IDLE_ADDR;
                wrtEn    <= 1'b0;
                bus.ack0 <= ~owner;
                bus.ack1 <= owner;
                if (!wrtEn) bus.rdata <= dbus;
            end else if (state == ST_DONE) begin
                bus.gnt <= 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_grant) lat_wdata <= grant_id ? bus.wdata1 : bus.wdata0;
    end

    // wrtEn is only ever set for the XFER cycle, so the bus is released everywhere else.
    assign dbus = (state == ST_XFER && wrtEn) ? lat_wdata : {DBITS{1'bz}};

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with a HEX register device and a default
// responder that returns zero for unmapped reads.
module tb_io_bus_arbiter;
    import io_bus_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        wrtEn;
    wire  [31:0] dbus;

    logic [15:0] hex_reg;
    logic        hex_load;
    logic [15:0] hex_load_val;

    int n_checks = 0;
    int n_errors = 0;

    io_bus_arbiter_if #(.DBITS(32)) bus_i ();

    io_bus_arbiter #(.DBITS(32), .IDLE_ADDR(32'h0), .MAX_BURST(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_i),
        .address (address),
        .wrtEn   (wrtEn),
        .dbus    (dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dbus = (!wrtEn) ? ((address == HEX_ADDR) ? {16'h0, hex_reg} : 32'h0) : {32{1'bz}};

    always @(posedge clk) begin
        if (hex_load)                           hex_reg <= hex_load_val;
        else if (wrtEn && address == HEX_ADDR)  hex_reg <= dbus[15:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat();
        return {28'h0, bus_i.gnt, bus_i.ack1, bus_i.ack0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp3 [8];
    logic [3:0] exp4 [10];

    initial begin
        exp3 = '{4'h4, 4'h5, 4'h8, 4'hA, 4'h4, 4'h5, 4'h8, 4'hA};
        exp4 = '{4'h4, 4'h5, 4'h4, 4'h5, 4'h4, 4'h5, 4'h4, 4'h5, 4'h8, 4'hA};

        reset = 1'b0;
        hex_load = 1'b0; hex_load_val = '0;
        bus_i.req0 = 0; bus_i.req1 = 0; bus_i.lock0 = 0; bus_i.lock1 = 0;
        bus_i.we0 = 0; bus_i.we1 = 0;
        bus_i.addr0 = '0; bus_i.addr1 = '0; bus_i.wdata0 = '0; bus_i.wdata1 = '0;

        repeat (2) tick();
        check("rst addr", address, 32'h0);
        check("rst wrtEn", {31'h0, wrtEn}, 32'h0);
        check("rst stat", stat(), 32'h0);
        check("rst rdata", bus_i.rdata, 32'h0);
        check("rst dbus", dbus, 32'h0);
        reset = 1'b1;

        // idle bus
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle addr", address, 32'h0);
            check("idle ctl", {stat()[27:0], dbus[3:0]} | {31'h0, wrtEn}, 32'h0);
        end

        // single write to HEX
        bus_i.req0 = 1; bus_i.we0 = 1; bus_i.addr0 = HEX_ADDR; bus_i.wdata0 = 32'h0000_1234;
        tick();
        check("wr xfer addr", address, HEX_ADDR);
        check("wr xfer wrtEn", {31'h0, wrtEn}, 32'h1);
        check("wr xfer dbus", dbus, 32'h0000_1234);
        check("wr xfer stat", stat(), 32'h4);
        tick();
        check("wr done stat", stat(), 32'h5);
        check("wr done addr", address, 32'h0);
        check("wr done wrtEn", {31'h0, wrtEn}, 32'h0);
        check("wr done dbus", dbus, 32'h0);
        bus_i.req0 = 0; bus_i.we0 = 0;
        tick();
        check("wr idle stat", stat(), 32'h0);
        check("wr hex", {16'h0, hex_reg}, 32'h0000_1234);

        // read from HEX by master 1
        hex_load = 1; hex_load_val = 16'hBEEF;
        tick();
        hex_load = 0;
        bus_i.req1 = 1; bus_i.we1 = 0; bus_i.addr1 = HEX_ADDR;
        tick();
        check("rd xfer stat", stat(), 32'h8);
        check("rd xfer addr", address, HEX_ADDR);
        check("rd xfer wrtEn", {31'h0, wrtEn}, 32'h0);
        check("rd xfer dbus", dbus, 32'h0000_BEEF);
        tick();
        check("rd done stat", stat(), 32'hA);
        check("rd rdata", bus_i.rdata, 32'h0000_BEEF);
        bus_i.req1 = 0;
        tick();
        check("rd idle stat", stat(), 32'h0);
        check("rd rdata hold", bus_i.rdata, 32'h0000_BEEF);

        // conflict from reset: alternating grants
        reset = 0;
        tick();
        reset = 1;
        bus_i.req0 = 1; bus_i.req1 = 1; bus_i.we0 = 1; bus_i.we1 = 1;
        bus_i.addr0 = LEDR_ADDR; bus_i.addr1 = LEDR_ADDR;
        bus_i.wdata0 = 32'h11; bus_i.wdata1 = 32'h22;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr stat", stat(), {28'h0, exp3[i]});
            if (i % 2 == 0)
                check("rr dbus", dbus, (exp3[i] == 4'h4) ? 32'h11 : 32'h22);
            if (i == 7) begin bus_i.req0 = 0; bus_i.req1 = 0; end
        end
        tick();
        check("rr idle stat", stat(), 32'h0);

        // locked burst capped at 4, then master 1
        bus_i.lock0 = 1; bus_i.req0 = 1; bus_i.req1 = 1;
        bus_i.wdata0 = 32'hA0; bus_i.wdata1 = 32'hB1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("burst stat", stat(), {28'h0, exp4[i]});
            if (i < 8 && i % 2 == 0) check("burst dbus", dbus, 32'hA0 + 32'(i / 2));
            if (i < 7 && i % 2 == 1) bus_i.wdata0 = 32'hA0 + 32'((i + 1) / 2);
            if (i == 8) begin
                check("burst m1 dbus", dbus, 32'hB1);
                bus_i.req0 = 0; bus_i.lock0 = 0;
            end
            if (i == 9) bus_i.req1 = 0;
        end
        tick();
        check("burst idle stat", stat(), 32'h0);

        // reset in the middle of a write XFER
        bus_i.req0 = 1; bus_i.we0 = 1; bus_i.addr0 = HEX_ADDR; bus_i.wdata0 = 32'h5555;
        tick();
        check("mid xfer wrtEn", {31'h0, wrtEn}, 32'h1);
        #2 reset = 0;
        #1;
        check("mid rst addr", address, 32'h0);
        check("mid rst wrtEn", {31'h0, wrtEn}, 32'h0);
        check("mid rst stat", stat(), 32'h0);
        check("mid rst dbus", dbus, 32'h0);
        bus_i.req0 = 0; bus_i.we0 = 0;
        tick();
        check("mid rst no ack", stat(), 32'h0);
        tick();
        check("mid rst hex", {16'h0, hex_reg}, 32'h0000_BEEF);
        reset = 1;
        bus_i.req0 = 1; bus_i.we0 = 1; bus_i.addr0 = HEX_ADDR; bus_i.wdata0 = 32'h7777;
        bus_i.req1 = 1; bus_i.we1 = 0; bus_i.addr1 = HEX_ADDR;
        tick();
        check("post rst stat", stat(), 32'h4);
        check("post rst dbus", dbus, 32'h7777);
        tick();
        check("post rst ack0", stat(), 32'h5);
        bus_i.req0 = 0;
        tick();
        check("post rst m1", stat(), 32'h8);
        check("post rst rd dbus", dbus, 32'h7777);
        tick();
        check("post rst ack1", stat(), 32'hA);
        check("post rst rdata", bus_i.rdata, 32'h7777);
        bus_i.req1 = 0;
        tick();
        check("final idle", stat(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
